// File: rtl/loader_pkg.sv
// Shared types and field sizes for the boot-time program loader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package loader_pkg;

   // Header (word count) and trailer (checksum) field lengths in bytes
   localparam int LOADER_HDR_BYTES = 4;
   localparam int LOADER_CHK_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CHK,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; shared by length, data and checksum fields.
// Latency: word/word_valid are combinational with the 4th byte's rx_valid (the caller registers them).
// Backpressure: none, one byte accepted per rx_valid; clr discards any partial word.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic [31:0] word,
   output logic        word_valid
);

   // The packer must cover the widest field it is reused for
   localparam int PACK_BYTES = (LOADER_HDR_BYTES > LOADER_CHK_BYTES) ? LOADER_HDR_BYTES : LOADER_CHK_BYTES;
   localparam int IDX_W = $clog2(PACK_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_BYTES - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      word_q, word_d;

   // Merge the incoming byte into its lane and advance the byte index
   always_comb begin
      word = word_q;
      word[idx_q*8 +: 8] = rx_data;
      word_valid = rx_valid && (idx_q == LAST_IDX);
      idx_d  = idx_q;
      word_d = word_q;
      if (clr) begin
         idx_d  = '0;
         word_d = '0;
      end else if (rx_valid) begin
         idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         word_d = word_valid ? '0 : word;
      end
   end

   // Partial-word state
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// UART-fed boot loader: length header, N little-endian words to flash_*, optional checksum (LOADER_CHECKSUM_EN).
// Latency: flash_en one cycle after a word's 4th byte; done one cycle after the final write (or after the checksum).
// Backpressure: none, always ready; rx_valid ignored in IDLE/DONE, start ignored while busy.
module program_loader
   import loader_pkg::*;
#(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             flash_en,
   output logic [WIDTH-1:0] flash_addr,
   output logic [WIDTH-1:0] flash_data,
   output logic             cpu_rst,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   loader_state_t    state_q, state_d;
   logic [CW-1:0]    n_q, n_d;
   logic [CW-1:0]    wcnt_q, wcnt_d;
   logic             fin_q, fin_d;
   logic             flash_en_q, flash_en_d;
   logic [WIDTH-1:0] flash_addr_q, flash_addr_d;
   logic [WIDTH-1:0] flash_data_q, flash_data_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]      sum_q, sum_d;
`endif

   logic             pk_clr;
   logic             pk_valid;
   logic [31:0]      pk_word;
   logic             pk_word_valid;

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (pk_clr),
      .rx_valid   (pk_valid),
      .rx_data    (rx_data),
      .word       (pk_word),
      .word_valid (pk_word_valid)
   );

   // Next-state and next-output computation for the load sequence
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      wcnt_d       = wcnt_q;
      fin_d        = fin_q;
      flash_en_d   = 1'b0;
      flash_addr_d = flash_addr_q;
      flash_data_d = flash_data_q;
      error_d      = error_q;
      pk_clr       = 1'b0;
      pk_valid     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LEN;
               error_d = 1'b0;
               wcnt_d  = '0;
               fin_d   = 1'b0;
               pk_clr  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         ST_LEN: begin
            pk_valid = rx_valid;
            if (pk_word_valid) begin
               if (pk_word > 32'(MAX_WORDS)) begin
                  error_d = 1'b1;
                  state_d = ST_DONE;
               end else if (pk_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  n_d     = CW'(pk_word);
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            // fin_q: last write is on flash_* now, DONE follows it by one cycle
            pk_valid = rx_valid && !fin_q;
            if (fin_q) begin
               state_d = ST_DONE;
            end else if (pk_word_valid) begin
               flash_en_d   = 1'b1;
               flash_addr_d = WIDTH'(BASE_ADDR) + (WIDTH'(wcnt_q) << 2);
               flash_data_d = WIDTH'(pk_word);
               wcnt_d       = wcnt_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
               sum_d        = sum_q + pk_word;
               if (wcnt_d == n_q) state_d = ST_CHK;
`else
               if (wcnt_d == n_q) fin_d = 1'b1;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            pk_valid = rx_valid;
            if (pk_word_valid) begin
               error_d = (pk_word != sum_q);
               state_d = ST_DONE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      busy_d    = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
      done_d    = (state_d == ST_DONE);
      cpu_rst_d = !(done_d && !error_d);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         n_q          <= '0;
         wcnt_q       <= '0;
         fin_q        <= 1'b0;
         flash_en_q   <= 1'b0;
         flash_addr_q <= WIDTH'(BASE_ADDR);
         flash_data_q <= '0;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         wcnt_q       <= wcnt_d;
         fin_q        <= fin_d;
         flash_en_q   <= flash_en_d;
         flash_addr_q <= flash_addr_d;
         flash_data_q <= flash_data_d;
         cpu_rst_q    <= cpu_rst_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign flash_en   = flash_en_q;
   assign flash_addr = flash_addr_q;
   assign flash_data = flash_data_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: image-level model of expected writes plus literal timing checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_program_loader;

   localparam logic [31:0] BASE = 32'hFFFF_FFF8;  // near the top so addresses wrap
   localparam int          MAXW = 8;

   logic        clk = 1'b0;
   logic        rst, start, rx_valid;
   logic [7:0]  rx_data;
   logic        flash_en, cpu_rst, busy, done, error;
   logic [31:0] flash_addr, flash_data;

   program_loader #(.WIDTH(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .flash_en   (flash_en),
      .flash_addr (flash_addr),
      .flash_data (flash_data),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_addr[$], exp_data[$];
   logic [31:0] log_addr[$], log_data[$];
   int          log_cyc[$];
   logic [31:0] img[$];
   logic [7:0]  tx[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Every write must be the next one the image model predicts
   always @(negedge clk) begin
      if (flash_en === 1'b1) begin
         log_addr.push_back(flash_addr);
         log_data.push_back(flash_data);
         log_cyc.push_back(cyc);
         if (exp_addr.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr %h data %h, want no write", flash_addr, flash_data);
         end else begin
            chk("wr_addr", flash_addr, exp_addr.pop_front());
            chk("wr_data", flash_data, exp_data.pop_front());
         end
      end
   end

   // Model: serialise header and words, predict one write per word at BASE + 4*i
   task automatic build(input logic [31:0] n);
      logic [31:0] w;
      tx.delete();
      for (int b = 0; b < 4; b++) tx.push_back(n[8*b +: 8]);
      if (n <= MAXW) begin
         for (int i = 0; i < int'(n); i++) begin
            w = img[i];
            for (int b = 0; b < 4; b++) tx.push_back(w[8*b +: 8]);
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(w);
         end
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   function automatic logic [31:0] img_sum();
      logic [31:0] s = 32'd0;
      foreach (img[i]) s = s + img[i];
      return s;
   endfunction

   task automatic append_chk(input logic [31:0] v);
      for (int b = 0; b < 4; b++) tx.push_back(v[8*b +: 8]);
   endtask
`endif

   task automatic pulse_start(input logic junk);
      @(negedge clk);
      start    = 1'b1;
      rx_valid = junk;
      rx_data  = 8'hAA;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
   endtask

   // Back-to-back bytes; returns on the negedge after the last byte was sampled
   task automatic send(input int start_at, input int count);
      for (int i = 0; i < count; i++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = tx[i];
         start    = (i == start_at);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int lim);
      int k = 0;
      while (done !== 1'b1 && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {31'd0, done}, 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_flash_en"},   {31'd0, flash_en}, 32'd0);
      chk({tag, "_flash_addr"}, flash_addr, BASE);
      chk({tag, "_flash_data"}, flash_data, 32'd0);
      chk({tag, "_cpu_rst"},    {31'd0, cpu_rst}, 32'd1);
      chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
      chk({tag, "_done"},       {31'd0, done}, 32'd0);
      chk({tag, "_error"},      {31'd0, error}, 32'd0);
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;

      // A: two-word image, start coincident with a byte that must be dropped
      clear_log();
      img = '{32'h0000_0013, 32'hDEAD_BEEF};
      build(32'd2);
`ifdef LOADER_CHECKSUM_EN
      chk("A_model_sum", img_sum(), 32'hDEAD_BF02);
      append_chk(32'hDEAD_BF02);
`endif
      pulse_start(1'b1);
      send(-1, tx.size());
`ifndef LOADER_CHECKSUM_EN
      chk("A_last_flash_en", {31'd0, flash_en}, 32'd1);
      chk("A_done_not_yet", {31'd0, done}, 32'd0);
      @(negedge clk);
`endif
      chk("A_done", {31'd0, done}, 32'd1);
      chk("A_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("A_error", {31'd0, error}, 32'd0);
      chk("A_busy", {31'd0, busy}, 32'd0);
      chk("A_nwrites", log_addr.size(), 32'd2);
      chk("A_wr0_addr_lit", log_addr[0], 32'hFFFF_FFF8);
      chk("A_wr0_data_lit", log_data[0], 32'h0000_0013);
      chk("A_wr1_addr_lit", log_addr[1], 32'hFFFF_FFFC);
      chk("A_wr1_data_lit", log_data[1], 32'hDEAD_BEEF);
      chk("A_pending", exp_addr.size(), 32'd0);

      // B: empty image finishes the cycle after the last header (or checksum) byte
      clear_log();
      img.delete();
      build(32'd0);
`ifdef LOADER_CHECKSUM_EN
      append_chk(32'd0);
`endif
      pulse_start(1'b0);
      chk("B_busy", {31'd0, busy}, 32'd1);
      chk("B_done_low", {31'd0, done}, 32'd0);
      send(-1, tx.size());
      chk("B_done", {31'd0, done}, 32'd1);
      chk("B_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("B_error", {31'd0, error}, 32'd0);
      chk("B_nwrites", log_addr.size(), 32'd0);

      // C: oversize image is rejected without writes; later bytes ignored in DONE
      clear_log();
      build(32'(MAXW + 1));
      pulse_start(1'b0);
      send(-1, tx.size());
      chk("C_done", {31'd0, done}, 32'd1);
      chk("C_error", {31'd0, error}, 32'd1);
      chk("C_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      tx = '{8'h11, 8'h22, 8'h33, 8'h44};
      send(-1, 4);
      repeat (3) @(negedge clk);
      chk("C_nwrites", log_addr.size(), 32'd0);
      chk("C_error_sticky", {31'd0, error}, 32'd1);

      // D: three words back-to-back from DONE, stray start mid-stream, address wrap
      clear_log();
      img = '{32'h0403_0201, 32'h8877_6655, 32'hCAFE_F00D};
      build(32'd3);
`ifdef LOADER_CHECKSUM_EN
      append_chk(img_sum());
`endif
      pulse_start(1'b0);
      chk("D_error_cleared", {31'd0, error}, 32'd0);
      send(6, tx.size());
      wait_done("D_done", 4);
      chk("D_error", {31'd0, error}, 32'd0);
      chk("D_nwrites", log_addr.size(), 32'd3);
      chk("D_gap01", 32'(log_cyc[1] - log_cyc[0]), 32'd4);
      chk("D_gap12", 32'(log_cyc[2] - log_cyc[1]), 32'd4);
      chk("D_wr0_data_lit", log_data[0], 32'h0403_0201);
      chk("D_wr2_addr_lit", log_addr[2], 32'h0000_0000);
      chk("D_pending", exp_addr.size(), 32'd0);

      // E: reset after the 6th data byte, then a clean reload
      clear_log();
      img = '{32'h1111_1111, 32'h2222_2222};
      build(32'd2);
      pulse_start(1'b0);
      send(-1, 10);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("E_midrst");
      chk("E_pending_at_rst", exp_addr.size(), 32'd1);
      exp_addr.delete();
      exp_data.delete();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("E_nwrites_aborted", log_addr.size(), 32'd1);
      clear_log();
      img = '{32'h1234_5678};
      build(32'd1);
`ifdef LOADER_CHECKSUM_EN
      append_chk(img_sum());
`endif
      pulse_start(1'b0);
      send(-1, tx.size());
      wait_done("E_done", 4);
      chk("E_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("E_wr0_addr_lit", log_addr[0], 32'hFFFF_FFF8);
      chk("E_pending", exp_addr.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // F: checksum off by one flags an error and keeps the core in reset
      clear_log();
      img = '{32'h0000_0013, 32'hDEAD_BEEF};
      build(32'd2);
      append_chk(32'hDEAD_BF03);
      pulse_start(1'b0);
      send(-1, tx.size());
      chk("F_done", {31'd0, done}, 32'd1);
      chk("F_error", {31'd0, error}, 32'd1);
      chk("F_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("F_pending", exp_addr.size(), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
